// File: rtl/dsm_pkg.sv
// Shared types and arithmetic helpers for the second-order delta-sigma transmitter.
// Holds the sequencer state encoding, accumulator widths and feedback levels.
// The saturating clamp keeps the integrators inside the signed 24-bit range.
package dsm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BITS = 2'd1,
    FILT = 2'd2
  } state_t;

  localparam int ACC_W = 24;
  localparam int SUM_W = 26;

  localparam logic signed [ACC_W-1:0] FB_POS = 24'sd32768;
  localparam logic signed [ACC_W-1:0] FB_NEG = -24'sd32768;

  localparam logic signed [SUM_W-1:0] SUM_MAX = 26'sd8388607;
  localparam logic signed [SUM_W-1:0] SUM_MIN = -26'sd8388608;

  // Clamp a 26-bit intermediate sum back into the 24-bit integrator range.
  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (v > SUM_MAX) begin
      sat = 24'sd8388607;
    end else if (v < SUM_MIN) begin
      sat = -24'sd8388607 - 24'sd1;
    end else begin
      sat = v[ACC_W-1:0];
    end
  endfunction

endpackage

// File: rtl/counter.sv
// Free-running modulo counter: counts 0..MAX_COUNT-1 while enabled, then wraps to 0.
// Latency: count updates on the clock edge after en is sampled high.
// No backpressure; holds its value while en is low.
module counter #(
  parameter int MAX_COUNT = 512,
  parameter int CW = $clog2(MAX_COUNT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] count
);

  // Advance and wrap at the terminal value; reset returns to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      if (count == CW'(MAX_COUNT - 1)) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with occupancy count, read/write pointers and full/empty flags.
// Latency: a written entry becomes visible at dout one cycle later (empty is registered).
// Push while full and pop while empty are dropped internally.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsm_tx.sv
// Second-order 1-bit delta-sigma transmitter: PCM samples in, OSR-bit frames plus end-of-frame strobe out.
// Latency: first bit appears 3 cycles after the first accepted push; frames repeat every OSR+1 cycles.
// Ready drops when the sample FIFO is full; an empty FIFO at frame start repeats x and pulses Underrun.
module dsm_tx
  import dsm_pkg::*;
#(
  parameter int OSR = 512,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] Din,
  input  logic        PushIn,
  output logic        Ready,
  output logic        BitOut,
  output logic        FilterOut,
  output logic        Underrun
);

  localparam int IDX_W = $clog2(OSR);

  state_t                  state;
  state_t                  state_nxt;
  logic [IDX_W-1:0]        bit_idx;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [15:0]             fifo_dout;
  logic                    push;
  logic                    pop;
  logic                    mod_en;
  logic                    underrun_set;
  logic signed [15:0]      x;
  logic signed [ACC_W-1:0] int1;
  logic signed [ACC_W-1:0] int2;
  logic signed [ACC_W-1:0] fb;
  logic signed [SUM_W-1:0] sum1;
  logic signed [SUM_W-1:0] sum2;
  logic                    b;

  assign Ready = !fifo_full && !Reset;
  assign push  = PushIn && Ready;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (16)
  ) u_fifo (
    .clk   (Clock),
    .reset (Reset),
    .push  (push),
    .din   (Din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  counter #(
    .MAX_COUNT (OSR)
  ) u_bit_idx (
    .clk   (Clock),
    .reset (Reset),
    .en    (state == BITS),
    .count (bit_idx)
  );

  // Sequencer state register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: wait for the first sample, then alternate OSR bit cycles with one filter cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!fifo_empty) state_nxt = BITS;
      BITS:    if (bit_idx == IDX_W'(OSR - 1)) state_nxt = FILT;
      FILT:    state_nxt = BITS;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state controls: frame boundaries pop the next sample, bit cycles run the loop.
  always_comb begin
    pop          = 1'b0;
    mod_en       = 1'b0;
    underrun_set = 1'b0;
    unique case (state)
      IDLE: pop = !fifo_empty;
      BITS: mod_en = 1'b1;
      FILT: begin
        pop          = !fifo_empty;
        underrun_set = fifo_empty;
      end
      default: ;
    endcase
  end

  // Quantiser, feedback level and 26-bit loop sums; int2 uses the pre-update int1.
  always_comb begin
    b    = !int2[ACC_W-1];
    fb   = b ? FB_POS : FB_NEG;
    sum1 = SUM_W'(int1) + SUM_W'(x) - SUM_W'(fb);
    sum2 = SUM_W'(int2) + SUM_W'(int1) - SUM_W'(fb);
  end

  // Hold register, integrators and registered outputs; integrators freeze outside bit cycles.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      x         <= '0;
      int1      <= '0;
      int2      <= '0;
      BitOut    <= 1'b0;
      FilterOut <= 1'b0;
      Underrun  <= 1'b0;
    end else begin
      if (pop) begin
        x <= fifo_dout;
      end
      if (mod_en) begin
        int1 <= sat(sum1);
        int2 <= sat(sum2);
      end
      BitOut    <= mod_en && b;
      FilterOut <= (state == FILT);
      Underrun  <= underrun_set;
    end
  end

endmodule

// File: tb/tb_dsm_tx.sv
// Scoreboard bench for dsm_tx: expected per-frame ones counts and Underrun flags are queued at stimulus time.
// A monitor counts BitOut ones between FilterOut strobes and checks each frame against the queue.
// Directed cases: mid-scale, both rails, +half scale, back-to-back FIFO fill, and reset mid-frame.
module tb_dsm_tx;

  localparam int OSR   = 512;
  localparam int DEPTH = 4;
  localparam int FRAME = OSR + 1;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] Din = '0;
  logic        PushIn = 1'b0;
  logic        Ready;
  logic        BitOut;
  logic        FilterOut;
  logic        Underrun;

  dsm_tx #(
    .OSR        (OSR),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Din       (Din),
    .PushIn    (PushIn),
    .Ready     (Ready),
    .BitOut    (BitOut),
    .FilterOut (FilterOut),
    .Underrun  (Underrun)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int lo;
    int hi;
    int und;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      if (lo == hi) $display("FAIL %s: got %0d, expected %0d", name, act, lo);
      else          $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic expect_frame(input int lo, input int hi, input int und);
    exp_t e;
    e.lo  = lo;
    e.hi  = hi;
    e.und = und;
    sb.push_back(e);
  endtask

  // Monitor: one frame ends at each FilterOut strobe.
  int   ones = 0;
  int   since = 0;
  bit   have_prev = 1'b0;
  exp_t cur;

  always @(negedge Clock) begin
    if (Reset) begin
      ones      = 0;
      since     = 0;
      have_prev = 1'b0;
    end else begin
      since++;
      if (FilterOut) begin
        chk("bit_during_filter", int'(BitOut), 0, 0);
        if (have_prev) chk("frame_period", since, FRAME, FRAME);
        if (sb.size() == 0) begin
          chk("unexpected_frame", 1, 0, 0);
        end else begin
          cur = sb.pop_front();
          chk("frame_ones", ones, cur.lo, cur.hi);
          chk("frame_underrun", int'(Underrun), cur.und, cur.und);
        end
        ones      = 0;
        since     = 0;
        have_prev = 1'b1;
      end else begin
        if (Underrun) chk("stray_underrun", 1, 0, 0);
        if (BitOut) ones++;
      end
    end
  end

  task automatic do_reset();
    @(negedge Clock);
    Reset  = 1'b1;
    PushIn = 1'b0;
    @(negedge Clock);
    chk("reset_bitout", int'(BitOut), 0, 0);
    chk("reset_filterout", int'(FilterOut), 0, 0);
    chk("reset_underrun", int'(Underrun), 0, 0);
    chk("reset_ready", int'(Ready), 0, 0);
    Reset = 1'b0;
    @(negedge Clock);
    chk("ready_after_release", int'(Ready), 1, 1);
  endtask

  task automatic push(input logic [15:0] v);
    @(negedge Clock);
    chk("ready_before_push", int'(Ready), 1, 1);
    Din    = v;
    PushIn = 1'b1;
    @(negedge Clock);
    PushIn = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge Clock);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout_pending", sb.size(), 0, 0);
      sb.delete();
    end
  endtask

  logic [15:0] burst [5];
  int          q_ones;
  int          q_filt;

  initial begin
    burst[0] = 16'd0;
    burst[1] = 16'd16384;
    burst[2] = 16'hC000;
    burst[3] = 16'd0;
    burst[4] = 16'd16384;

    // Mid-scale input: half density, FIFO empty at every frame boundary.
    do_reset();
    push(16'd0);
    repeat (4) expect_frame(254, 258, 1);
    drain(4 * FRAME + 50);

    // Positive rail.
    do_reset();
    push(16'h7FFF);
    repeat (3) expect_frame(510, 512, 1);
    drain(3 * FRAME + 50);

    // Negative rail.
    do_reset();
    push(16'h8000);
    repeat (3) expect_frame(0, 2, 1);
    drain(3 * FRAME + 50);

    // +half scale, single sample repeated through underruns.
    do_reset();
    push(16'd16384);
    repeat (3) expect_frame(382, 386, 1);
    drain(3 * FRAME + 50);

    // Back-to-back fill from IDLE; the sixth push meets a full FIFO.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      chk("burst_ready", int'(Ready), 1, 1);
      Din    = burst[i];
      PushIn = 1'b1;
    end
    @(negedge Clock);
    chk("ready_full", int'(Ready), 0, 0);
    Din    = 16'h8000;
    PushIn = 1'b1;
    @(negedge Clock);
    PushIn = 1'b0;
    chk("ready_still_full", int'(Ready), 0, 0);
    expect_frame(254, 258, 0);
    expect_frame(382, 386, 0);
    expect_frame(126, 130, 0);
    expect_frame(254, 258, 0);
    expect_frame(382, 386, 1);
    expect_frame(382, 386, 1);
    drain(6 * FRAME + 50);

    // Reset around bit index 200 while a push is offered.
    do_reset();
    push(16'd16384);
    repeat (200) @(negedge Clock);
    Reset  = 1'b1;
    Din    = 16'd5;
    PushIn = 1'b1;
    @(negedge Clock);
    chk("midrst_bitout", int'(BitOut), 0, 0);
    chk("midrst_filterout", int'(FilterOut), 0, 0);
    chk("midrst_underrun", int'(Underrun), 0, 0);
    chk("midrst_ready", int'(Ready), 0, 0);
    Reset  = 1'b0;
    PushIn = 1'b0;
    @(negedge Clock);
    chk("midrst_ready_release", int'(Ready), 1, 1);
    q_ones = 0;
    q_filt = 0;
    repeat (2 * FRAME) begin
      @(negedge Clock);
      if (BitOut) q_ones++;
      if (FilterOut) q_filt++;
    end
    chk("idle_after_reset_bits", q_ones, 0, 0);
    chk("idle_after_reset_filter", q_filt, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dsm_tx.md
DSM_TX -- requirements
Module: dsm_tx

Interface
REQ-001 SHALL have parameter OSR, default 512, meaning bit cycles per output frame (power of two, 16..1024).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of input sample entries (power of two, at least 2).
REQ-003 SHALL have port Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port Din, input, 16 bits: signed PCM sample.
REQ-006 SHALL have port PushIn, input, 1 bit: Din is valid this cycle.
REQ-007 SHALL have port Ready, output, 1 bit: the FIFO can accept a sample this cycle.
REQ-008 SHALL have port BitOut, output, 1 bit: the registered delta-sigma bitstream.
REQ-009 SHALL have port FilterOut, output, 1 bit: registered end-of-frame strobe, driving the decimator's FILTER input.
REQ-010 SHALL have port Underrun, output, 1 bit: one-cycle pulse when a frame starts with the FIFO empty.

Function
REQ-011 SHALL use Ready = FIFO not full AND not Reset, combinational from the registered occupancy count.
REQ-012 SHALL write Din into the FIFO when PushIn and Ready are both high; PushIn while Ready is low SHALL be ignored and SHALL NOT change the FIFO.
REQ-013 SHALL allow a push and a pop in the same cycle with the occupancy unchanged; a push into an empty FIFO SHALL NOT be poppable in that same cycle.
REQ-014 SHALL implement the state machine IDLE, BITS, FILT.
REQ-015 In IDLE, with the FIFO non-empty, SHALL pop into the hold register x and go to BITS; otherwise it SHALL stay in IDLE.
REQ-016 BITS SHALL last exactly OSR cycles, with the bit index running 0..OSR-1; at index OSR-1 it SHALL go to FILT.
REQ-017 FILT SHALL last 1 cycle and then go to BITS; in FILT it SHALL pop the next sample into x if the FIFO is non-empty, else keep x and pulse Underrun.
REQ-018 The frame period SHALL be exactly OSR+1 cycles in steady state, with no gaps.
REQ-019 The modulator SHALL be second order, with signed 24-bit integrators int1 and int2.
REQ-020 Each BITS cycle SHALL compute: b = (int2 >= 0); fb = b ? +32768 : -32768; int1 <= sat(int1 + x - fb); int2 <= sat(int2 + int1_old - fb).
REQ-021 sat() SHALL clamp to [-2^23, 2^23-1]; intermediate sums SHALL be computed at 26 bits, and Din SHALL be sign-extended.
REQ-022 BitOut SHALL equal b, registered: it is valid the cycle after each BITS cycle, and is 0 the cycle after FILT and IDLE cycles.
REQ-023 FilterOut SHALL be 1 exactly in the cycle after a FILT cycle and 0 otherwise; it SHALL never be high while a stream bit is presented.
REQ-024 In FILT and IDLE, int1 and int2 SHALL hold their values.
REQ-025 Mean BitOut density over a frame SHALL be (x+32768)/65536, within ±2 bits per 512.

Reset
REQ-026 Reset SHALL be sampled only on a Clock edge and SHALL take priority over all other activity, including mid-frame and mid-push.
REQ-027 Reset SHALL force: state IDLE, bit index 0, int1 = int2 = 0, x = 0, FIFO empty, BitOut = 0, FilterOut = 0, Underrun = 0, Ready = 0.
REQ-028 Ready SHALL be 1 in the first cycle after Reset is released.

Structure
REQ-029 Package dsm_pkg SHALL hold the state_t enum (IDLE, BITS, FILT), ACC_W = 24, FB_POS = +32768, FB_NEG = -32768, and the sat function.
REQ-030 The FIFO SHALL be sub-module sample_fifo: synchronous, occupancy count plus read and write pointers, and full/empty flags.
REQ-031 The bit index SHALL reuse the existing counter module, with MAX_COUNT set to OSR and enable tied to state == BITS.

Verification
REQ-032 Push Din = 0 and run 4 frames -> each frame has 256±2 ones and FilterOut pulses every 513 cycles.
REQ-033 Push Din = +32767 -> at least 510 ones per frame; push Din = -32768 -> at most 2 ones per frame; integrators never wrap.
REQ-034 Push Din = 16384 -> 384±2 ones per frame; a decimation filter fed BitOut/FilterOut outputs a steady value.
REQ-035 In IDLE, push 5 samples back-to-back -> first pops; Ready falls after the 5th accepted; a 6th PushIn is ignored; samples pop in order at 513-cycle spacing.
REQ-036 Push 1 sample and wait 2 frames -> Underrun pulses once per FILT; x is repeated; bitstream density is unchanged.
REQ-037 Assert Reset at bit index 200 -> the next cycle shows all outputs 0, state IDLE and FIFO empty; Ready = 1 one cycle after release.
